ctrl_sequencer: RTL
===================

# ctrl_sequencer

Parametrised control sequencer for the SAP-class accumulator CPU. It steps through fetch states T1–T3 and execute states T4–T6, and drives a 14-bit control word to the PC, MAR, RAM, IR, accumulator, B register, ALU, output register and flag register. Compared with the fixed six-state sequencer, it adds:
- jump and conditional-jump instructions,
- a flag-load strobe,
- optional early return to fetch (variable-length instructions),
- a resumable HALT state.

## Interface
- `OPW`, default 4: opcode width (≥4). Any opcode with nonzero bits above [3:0] decodes as NOP.
- `SKIP_IDLE`, default 1: 1 returns to T1 right after an instruction's last active T-state; 0 always runs all of T1–T6 (legacy timing).

Ports:
- `clk`  in  1  clock; the state register updates on the falling edge.
- `reset`  in  1  reset, asynchronous, active-low.
- `opcode`  in  OPW  IR opcode field; valid from T4 onward.
- `z`  in  1  registered zero flag; sampled combinationally in T4 of JZ.
- `resume`  in  1  leaves HALT; sampled at the falling edge.
- `cont`  out  14  control word. Bits: 13 CP, 12 EP, 11 LM_N, 10 CE_N, 9 LI_N, 8 EI_N, 7 LA_N, 6 EA, 5 SU, 4 EU, 3 LB_N, 2 LO_N, 1 LP, 0 LF.
- `tstate`  out  6  one-hot current T-state, T1 = bit 0; all zeros in HALT.
- `halted`  out  1  high in HALT.

## Operation
- States: T1, T2, T3, T4, T5, T6, HALT.
- IDLE word = 0x0F8C: all active-low bits at 1, all other bits at 0.
- Fetch sequence:
  - T1 = 0x178C (EP, LM_N).
  - T2 = 0x2F8C (CP).
  - T3 = 0x098C (CE_N, LI_N).
  - Fetch is the same for every opcode.
- Opcodes are defined in the package: LDA 0000, ADD 0001, SUB 0010, JMP 0100, JZ 0101, OUT 1110, HLT 1111. All other opcodes are NOP.
- Execute words per instruction (`cont` combinational from state, opcode and z):
  - LDA: T4 0x068C (EI_N, LM_N); T5 0x0B0C (CE_N, LA_N); T6 IDLE. Last active state T5.
  - ADD: T4 0x068C; T5 0x0B84 (CE_N, LB_N); T6 0x0F1D (EU, LA_N, LF). Last active state T6.
  - SUB: same as ADD, except T6 = 0x0F3D (adds SU).
  - OUT: T4 0x0FC8 (EA, LO_N). Last active state T4.
  - JMP: T4 0x0E8E (EI_N, LP). Last active state T4.
  - JZ: T4 0x0E8E if z=1, else IDLE. Last active state T4.
  - NOP: T4 IDLE. Last active state T4.
  - HLT: T4 IDLE; next state HALT.
  - Any T-state past an instruction's last active state outputs IDLE.
- Transitions:
  - T1→T2→T3→T4.
  - From T4/T5, with SKIP_IDLE=1: go to T1 if the current state is the instruction's last active state; otherwise advance. With SKIP_IDLE=0: always advance.
  - T6→T1.
  - T4 with HLT→HALT, regardless of SKIP_IDLE.
  - HALT: `cont` = IDLE; resume=1→T1; otherwise stay in HALT.
- An unreachable state encoding goes to T1 at the next falling edge and outputs IDLE.

## Timing
- Reset (asynchronous, low): state goes to T1 immediately. `cont` = 0x178C, `tstate` = 000001, `halted` = 0.
- Reset asserted mid-instruction aborts the instruction. No partial-state recovery.
- First falling edge after reset release moves to T2.
- State changes only on falling edges, so `cont` is stable across the following rising edge, where the datapath acts.
- Instruction length in cycles:
  - SKIP_IDLE=1: LDA 5, ADD/SUB 6, OUT/JMP/JZ/NOP 4.
  - SKIP_IDLE=0: all 6.
  - HLT: 4 cycles, then HALT.
- If `opcode` or z changes during T4–T6, `cont` follows combinationally. The datapath guarantees that IR and z are stable from T4 until fetch.
- `resume` asserted outside HALT: ignored.
- `resume` and reset together: reset wins.

## Structure
- Package `ctrl_seq_pkg`:
  - control-bit index constants and IDLE,
  - the seven opcode constants,
  - state enum (T1..T6, HALT).
- Sub-module `ctrl_seq_decode`: combinational microcode decoder. Inputs: state, opcode, z. Outputs: `cont` and `last`.
- Top level holds the state register, next-state logic and the SKIP_IDLE mux.

## Test plan
- Reset low at any state → `cont` = 0x178C, `tstate` = 000001 without a clock edge. After release, edges give T2 = 0x2F8C, then T3 = 0x098C.
- LDA, SKIP_IDLE=1 → T4 0x068C, T5 0x0B0C, next state T1 (5 cycles). With SKIP_IDLE=0 → extra T6 IDLE (6 cycles).
- SUB → T6 = 0x0F3D. ADD → T6 = 0x0F1D. Both return to T1 after T6.
- JZ with z=1 → T4 0x0E8E. JZ with z=0 → T4 0x0F8C. Both return to T1 after T4 (SKIP_IDLE=1).
- HLT → T4 IDLE, then HALT: `halted` = 1, `tstate` = 0, holds for 10 cycles. Then `resume` = 1 for one edge → T1, `cont` = 0x178C.
- Opcode 1010 (NOP) and OPW=6 with opcode 010000 → T4 IDLE, then T1. Reset asserted during T5 of ADD → immediate T1.

Source files
------------

// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_pkg
//   Shared definitions for the SAP-class control sequencer:
//   - bit positions of the 14-bit control word and the IDLE word,
//   - the instruction opcodes (4-bit field),
//   - the T-state enumeration,
//   - eff_opcode(): maps a raw opcode onto a defined opcode or OP_NOP.
package ctrl_seq_pkg;

  localparam int CW = 14;

  // Control word bit positions (_N bits are active-low)
  localparam int B_CP   = 13;
  localparam int B_EP   = 12;
  localparam int B_LM_N = 11;
  localparam int B_CE_N = 10;
  localparam int B_LI_N = 9;
  localparam int B_EI_N = 8;
  localparam int B_LA_N = 7;
  localparam int B_EA   = 6;
  localparam int B_SU   = 5;
  localparam int B_EU   = 4;
  localparam int B_LB_N = 3;
  localparam int B_LO_N = 2;
  localparam int B_LP   = 1;
  localparam int B_LF   = 0;

  // Every active-low strobe deasserted, every active-high strobe low (0x0F8C)
  localparam logic [CW-1:0] IDLE = (CW'(1) << B_LM_N) | (CW'(1) << B_CE_N) |
                                   (CW'(1) << B_LI_N) | (CW'(1) << B_EI_N) |
                                   (CW'(1) << B_LA_N) | (CW'(1) << B_LB_N) |
                                   (CW'(1) << B_LO_N);

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_JMP = 4'b0100;
  localparam logic [3:0] OP_JZ  = 4'b0101;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;
  // Canonical code for "no operation"; any undefined opcode maps here
  localparam logic [3:0] OP_NOP = 4'b0011;

  typedef enum logic [2:0] {
    T1   = 3'd0,
    T2   = 3'd1,
    T3   = 3'd2,
    T4   = 3'd3,
    T5   = 3'd4,
    T6   = 3'd5,
    HALT = 3'd6
  } state_t;

  // upper_nz: any opcode bit above [3:0] is set, which forces a NOP
  function automatic logic [3:0] eff_opcode(input logic [3:0] low,
                                            input logic       upper_nz);
    logic [3:0] op;
    op = OP_NOP;
    if (!upper_nz) begin
      case (low)
        OP_LDA, OP_ADD, OP_SUB, OP_JMP, OP_JZ, OP_OUT, OP_HLT: op = low;
        default: op = OP_NOP;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/ctrl_seq_decode.sv
// ctrl_seq_decode
//   Combinational microcode decoder.
//   Ports:
//     state  in  state_t   current T-state
//     opcode in  OPW       IR opcode field
//     z      in  1         zero flag (only JZ looks at it)
//     cont   out 14        control word for this state/opcode
//     last   out 1         current state is the instruction's last active one
module ctrl_seq_decode
  import ctrl_seq_pkg::*;
#(
  parameter int OPW = 4
) (
  input  state_t          state,
  input  logic [OPW-1:0]  opcode,
  input  logic            z,
  output logic [CW-1:0]   cont,
  output logic            last
);

  logic [3:0] op;

  // Shifting (rather than slicing) keeps OPW == 4 legal: the result is zero
  assign op = eff_opcode(opcode[3:0], |(opcode >> 4));

  // Start from IDLE and flip only the strobes each state needs
  always_comb begin
    cont = IDLE;
    last = 1'b1;
    case (state)
      T1: begin
        cont[B_EP]   = 1'b1;
        cont[B_LM_N] = 1'b0;
      end
      T2: cont[B_CP] = 1'b1;
      T3: begin
        cont[B_CE_N] = 1'b0;
        cont[B_LI_N] = 1'b0;
      end
      T4: begin
        case (op)
          OP_LDA, OP_ADD, OP_SUB: begin
            cont[B_EI_N] = 1'b0;
            cont[B_LM_N] = 1'b0;
            last         = 1'b0;
          end
          OP_OUT: begin
            cont[B_EA]   = 1'b1;
            cont[B_LO_N] = 1'b0;
          end
          OP_JMP: begin
            cont[B_EI_N] = 1'b0;
            cont[B_LP]   = 1'b1;
          end
          OP_JZ: begin
            if (z) begin
              cont[B_EI_N] = 1'b0;
              cont[B_LP]   = 1'b1;
            end
          end
          default: ;
        endcase
      end
      T5: begin
        case (op)
          OP_LDA: begin
            cont[B_CE_N] = 1'b0;
            cont[B_LA_N] = 1'b0;
          end
          OP_ADD, OP_SUB: begin
            cont[B_CE_N] = 1'b0;
            cont[B_LB_N] = 1'b0;
            last         = 1'b0;
          end
          default: ;
        endcase
      end
      T6: begin
        if (op == OP_ADD || op == OP_SUB) begin
          cont[B_EU]   = 1'b1;
          cont[B_LA_N] = 1'b0;
          cont[B_LF]   = 1'b1;
          cont[B_SU]   = (op == OP_SUB);
        end
      end
      default: ;  // HALT and unused encodings stay IDLE
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer
//   T-state sequencer for the SAP-class accumulator CPU. The state register
//   advances on the falling clock edge so the control word is settled at the
//   rising edge where the datapath acts.
//   Parameters:
//     OPW       opcode width (>= 4)
//     SKIP_IDLE 1: return to T1 after the last active state; 0: always T1..T6
//   Ports:
//     clk    in  1    clock (state updates on negedge)
//     reset  in  1    asynchronous, active-low
//     opcode in  OPW  IR opcode field
//     z      in  1    zero flag
//     resume in  1    leaves HALT
//     cont   out 14   control word
//     tstate out 6    one-hot T-state (T1 = bit 0), zero in HALT
//     halted out 1    high in HALT
module ctrl_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int OPW       = 4,
  parameter bit SKIP_IDLE = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OPW-1:0]  opcode,
  input  logic            z,
  input  logic            resume,
  output logic [CW-1:0]   cont,
  output logic [5:0]      tstate,
  output logic            halted
);

  state_t     state_reg;
  state_t     state_next;
  logic       last;
  logic [3:0] op;

  assign op = eff_opcode(opcode[3:0], |(opcode >> 4));

  ctrl_seq_decode #(
    .OPW(OPW)
  ) u_decode (
    .state  (state_reg),
    .opcode (opcode),
    .z      (z),
    .cont   (cont),
    .last   (last)
  );

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) state_reg <= T1;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = T1;
    case (state_reg)
      T1: state_next = T2;
      T2: state_next = T3;
      T3: state_next = T4;
      T4: begin
        if (op == OP_HLT)            state_next = HALT;
        else if (SKIP_IDLE && last)  state_next = T1;
        else                         state_next = T5;
      end
      T5: state_next = (SKIP_IDLE && last) ? T1 : T6;
      T6: state_next = T1;
      HALT: state_next = resume ? T1 : HALT;
      default: state_next = T1;  // unused encoding recovers to fetch
    endcase
  end

  always_comb begin
    tstate = '0;
    halted = 1'b0;
    case (state_reg)
      T1:   tstate[0] = 1'b1;
      T2:   tstate[1] = 1'b1;
      T3:   tstate[2] = 1'b1;
      T4:   tstate[3] = 1'b1;
      T5:   tstate[4] = 1'b1;
      T6:   tstate[5] = 1'b1;
      HALT: halted    = 1'b1;
      default: ;
    endcase
  end

endmodule
